// File: rtl/pedal_pkg.sv
// Shared types and constants for the pedal sample path (SPI, compression, adder).
package pedal_pkg;

   localparam int SAMPLE_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD
   } state_t;

   // Width of an unsigned counter that must hold 0 .. n_states-1 (never below 1 bit).
   function automatic int cnt_width(input int n_states);
      return (n_states > 1) ? $clog2(n_states) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SPI clock generator: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles,
// with one-cycle strobes marking the clk edge on which sclk rises or falls.
module spi_clk_div
   import pedal_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise_stb,
   output logic o_fall_stb
);

   localparam int DIV_W = cnt_width(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_div_cnt;
   logic             w_half_done;

   assign w_half_done = i_en & (r_div_cnt == DIV_LAST);

   // Strobes flag the edge on which sclk is about to toggle.
   assign o_rise_stb = w_half_done & ~o_sclk;
   assign o_fall_stb = w_half_done & o_sclk;

   // Half-period counter; held cleared with sclk low whenever the shifter is idle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !i_en) begin
         r_div_cnt <= '0;
         o_sclk    <= 1'b0;
      end else if (w_half_done) begin
         r_div_cnt <= '0;
         o_sclk    <= ~o_sclk;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_sample_xfer.sv
// Per-sample full-duplex SPI frame engine: each adc_clock rising edge sends the
// processed sample to the DAC on MOSI and captures the next ADC sample from MISO.
module spi_sample_xfer
   import pedal_pkg::*;
#(
   parameter int DATA_W   = SAMPLE_W,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_adc_clock,
   input  logic [DATA_W-1:0] i_dac_in,
   input  logic              i_miso,
   input  logic              i_overrun_clr,
   output logic              o_mosi,
   output logic              o_sclk,
   output logic              o_cs,
   output logic [DATA_W-1:0] o_adc_out,
   output logic              o_adc_valid,
   output logic              o_busy,
   output logic              o_overrun
);

   localparam int CNT_W = cnt_width((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
   localparam int BIT_W = cnt_width(DATA_W);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

   state_t            r_state;
   logic              r_adc_clock_q;
   logic [CNT_W-1:0]  r_cnt;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic [DATA_W-1:0] r_tx_sr;
   logic [DATA_W-1:0] r_rx_sr;

   logic w_start;
   logic w_shift_en;
   logic w_rise;
   logic w_fall;

   // adc_clock is already synchronous to clk, so a single history flop suffices.
   assign w_start    = i_adc_clock & ~r_adc_clock_q;
   assign w_shift_en = (r_state == SHIFT);
   assign o_busy     = (r_state != IDLE);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (w_shift_en),
      .o_sclk     (o_sclk),
      .o_rise_stb (w_rise),
      .o_fall_stb (w_fall)
   );

   // adc_clock history; resets high so a level held through reset is not an edge.
   // NOTE: every clocked block uses non-blocking assignments so all flops see
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_adc_clock_q <= 1'b1;
      else          r_adc_clock_q <= i_adc_clock;
   end

   // Sticky overrun: an edge arriving while a frame is in flight; set beats clear.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                   o_overrun <= 1'b0;
      else if (w_start && o_busy)     o_overrun <= 1'b1;
      else if (i_overrun_clr)         o_overrun <= 1'b0;
   end

   // Frame sequencer: IDLE -> SETUP (cs low) -> SHIFT (DATA_W bits) -> HOLD -> IDLE.
   // NOTE: the shift registers are reset along with the control state so a
   // frame aborted by reset leaves no stale partial word behind.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_bit_cnt   <= '0;
         r_tx_sr     <= '0;
         r_rx_sr     <= '0;
         o_cs        <= 1'b1;
         o_mosi      <= 1'b0;
         o_adc_out   <= '0;
         o_adc_valid <= 1'b0;
      end else begin
         o_adc_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_tx_sr <= i_dac_in;
                  o_mosi  <= i_dac_in[DATA_W-1];
                  o_cs    <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_cnt     <= '0;
                  r_bit_cnt <= '0;
                  r_state   <= SHIFT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (w_rise) r_rx_sr <= {r_rx_sr[DATA_W-2:0], i_miso};
               if (w_fall) begin
                  if (r_bit_cnt == BIT_LAST) begin
                     o_mosi  <= 1'b0;
                     r_cnt   <= '0;
                     r_state <= HOLD;
                  end else begin
                     r_tx_sr   <= r_tx_sr << 1;
                     o_mosi    <= r_tx_sr[DATA_W-2];
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  o_cs        <= 1'b1;
                  o_adc_out   <= r_rx_sr;
                  o_adc_valid <= 1'b1;
                  r_state     <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sample_xfer.sv
// Bench for spi_sample_xfer: a default instance and a minimum-timing instance,
// a cycle-level frame model built from the frame timing arithmetic, and an SPI
// slave that feeds MISO words and records what arrives on MOSI.
module tb_spi_sample_xfer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        adc_clock [2];
   logic [15:0] dac_in    [2];
   logic        miso      [2];
   logic        clr       [2];

   logic        cs_a    [2];
   logic        sclk_a  [2];
   logic        mosi_a  [2];
   logic        valid_a [2];
   logic        busy_a  [2];
   logic        ovr_a   [2];
   logic [15:0] adc_a   [2];

   spi_sample_xfer u_dut0 (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_adc_clock   (adc_clock[0]),
      .i_dac_in      (dac_in[0]),
      .i_miso        (miso[0]),
      .i_overrun_clr (clr[0]),
      .o_mosi        (mosi_a[0]),
      .o_sclk        (sclk_a[0]),
      .o_cs          (cs_a[0]),
      .o_adc_out     (adc_a[0]),
      .o_adc_valid   (valid_a[0]),
      .o_busy        (busy_a[0]),
      .o_overrun     (ovr_a[0])
   );

   spi_sample_xfer #(
      .CLK_DIV  (1),
      .CS_SETUP (1),
      .CS_HOLD  (1)
   ) u_dut1 (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_adc_clock   (adc_clock[1]),
      .i_dac_in      (dac_in[1]),
      .i_miso        (miso[1]),
      .i_overrun_clr (clr[1]),
      .o_mosi        (mosi_a[1]),
      .o_sclk        (sclk_a[1]),
      .o_cs          (cs_a[1]),
      .o_adc_out     (adc_a[1]),
      .o_adc_valid   (valid_a[1]),
      .o_busy        (busy_a[1]),
      .o_overrun     (ovr_a[1])
   );

   int cd  [2] = '{4, 1};
   int css [2] = '{2, 1};
   int csh [2] = '{2, 1};

   int n_tests = 0;
   int n_fail  = 0;

   // Frame model state.
   logic        m_prev_adc [2];
   logic        m_busy     [2];
   logic        m_ovr      [2];
   int          m_k        [2];
   logic [15:0] m_tx       [2];
   logic [15:0] m_rx       [2];
   logic [15:0] m_adc_out  [2];

   // SPI slave / frame monitor state.
   logic [15:0] miso_word [2];
   logic [15:0] cap       [2];
   int          frames    [2] = '{0, 0};
   int          len       [2] = '{0, 0};
   int          rises     [2] = '{0, 0};
   int          valid_cnt [2] = '{0, 0};
   int          bit_idx   [2] = '{0, 0};
   logic        vrise     [2];
   logic        p_cs      [2];
   logic        p_sclk    [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clk edge of the model for instance c, followed by the output comparison
   // and the slave/monitor update.
   task automatic step(input int c, input logic rs, input logic adc,
                       input logic [15:0] dac, input logic cl);
      int   half, flen, p;
      logic rise, e_valid, e_sclk, e_mosi;
      half    = cd[c];
      flen    = css[c] + 2 * half * 16 + csh[c];
      e_valid = 1'b0;
      if (!rs) begin
         m_prev_adc[c] = 1'b1;
         m_busy[c]     = 1'b0;
         m_ovr[c]      = 1'b0;
         m_adc_out[c]  = '0;
         miso[c]       = 1'b0;
      end else begin
         rise          = adc & ~m_prev_adc[c];
         m_prev_adc[c] = adc;
         if (m_busy[c]) begin
            m_k[c]++;
            if (rise)    m_ovr[c] = 1'b1;
            else if (cl) m_ovr[c] = 1'b0;
            if (m_k[c] == flen) begin
               m_busy[c]    = 1'b0;
               e_valid      = 1'b1;
               m_adc_out[c] = m_rx[c];
            end
         end else begin
            if (cl) m_ovr[c] = 1'b0;
            if (rise) begin
               m_busy[c] = 1'b1;
               m_k[c]    = 0;
               m_tx[c]   = dac;
               m_rx[c]   = miso_word[c];
            end
         end
      end
      e_sclk = 1'b0;
      e_mosi = 1'b0;
      if (m_busy[c]) begin
         p = m_k[c] - css[c];
         if (p < 0) begin
            e_mosi = m_tx[c][15];
         end else if (p < 2 * half * 16) begin
            e_sclk = ((p % (2 * half)) >= half);
            e_mosi = m_tx[c][15 - p / (2 * half)];
         end
      end
      check($sformatf("d%0d.cs", c),       cs_a[c],    !m_busy[c]);
      check($sformatf("d%0d.busy", c),     busy_a[c],  m_busy[c]);
      check($sformatf("d%0d.sclk", c),     sclk_a[c],  e_sclk);
      check($sformatf("d%0d.mosi", c),     mosi_a[c],  e_mosi);
      check($sformatf("d%0d.valid", c),    valid_a[c], e_valid);
      check($sformatf("d%0d.adc_out", c),  adc_a[c],   m_adc_out[c]);
      check($sformatf("d%0d.overrun", c),  ovr_a[c],   m_ovr[c]);

      if (cs_a[c] == 1'b0 && p_cs[c] == 1'b1) begin
         frames[c]++;
         len[c]     = 1;
         rises[c]   = 0;
         cap[c]     = '0;
         bit_idx[c] = 15;
         miso[c]    = miso_word[c][15];
      end else if (cs_a[c] == 1'b0) begin
         len[c]++;
      end
      if (cs_a[c] == 1'b0 && sclk_a[c] == 1'b1 && p_sclk[c] == 1'b0) begin
         rises[c]++;
         cap[c] = {cap[c][14:0], mosi_a[c]};
      end
      if (cs_a[c] == 1'b0 && sclk_a[c] == 1'b0 && p_sclk[c] == 1'b1 && bit_idx[c] > 0) begin
         bit_idx[c]--;
         miso[c] = miso_word[c][bit_idx[c]];
      end
      if (cs_a[c] == 1'b1 && p_cs[c] == 1'b0) vrise[c] = valid_a[c];
      if (valid_a[c] == 1'b1) valid_cnt[c]++;
      p_cs[c]   = cs_a[c];
      p_sclk[c] = sclk_a[c];
   endtask

   // Compare process: inputs as seen by the edge, outputs sampled 1 time unit later.
   always @(posedge clk) begin
      logic        s_rst;
      logic        s_adc [2];
      logic [15:0] s_dac [2];
      logic        s_clr [2];
      s_rst = rst_n;
      for (int c = 0; c < 2; c++) begin
         s_adc[c] = adc_clock[c];
         s_dac[c] = dac_in[c];
         s_clr[c] = clr[c];
      end
      #1;
      for (int c = 0; c < 2; c++) step(c, s_rst, s_adc[c], s_dac[c], s_clr[c]);
   end

   // Drive an adc_clock low/high pair and wait (bounded) for cs to fall.
   task automatic start_frame(input int c, input logic [15:0] word, input logic [15:0] mw);
      bit found;
      @(negedge clk);
      adc_clock[c] = 1'b0;
      dac_in[c]    = word;
      miso_word[c] = mw;
      @(negedge clk);
      adc_clock[c] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (cs_a[c] == 1'b0) found = 1'b1;
      end
      check($sformatf("d%0d.frame_start", c), found, 1'b1);
   endtask

   task automatic wait_frame_done(input int c);
      int vc;
      bit done;
      vc   = valid_cnt[c];
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (valid_cnt[c] != vc) done = 1'b1;
      end
      check($sformatf("d%0d.frame_done", c), done, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got time limit, expected bench completion");
      $fatal(1, "bench time limit");
   end

   initial begin
      int f0, v0;
      rst_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
         adc_clock[c] = 1'b1;
         dac_in[c]    = '0;
         clr[c]       = 1'b0;
         miso_word[c] = '0;
      end

      // Reset values, then release with adc_clock still high: no frame.
      repeat (4) @(negedge clk);
      check("rst.cs",      cs_a[0],    1'b1);
      check("rst.sclk",    sclk_a[0],  1'b0);
      check("rst.mosi",    mosi_a[0],  1'b0);
      check("rst.adc_out", adc_a[0],   16'h0000);
      check("rst.busy",    busy_a[0],  1'b0);
      check("rst.overrun", ovr_a[0],   1'b0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("rel.busy0",   busy_a[0],  1'b0);
      check("rel.busy1",   busy_a[1],  1'b0);
      check("rel.frames0", frames[0],  0);

      // Single default frame.
      start_frame(0, 16'hA5C3, 16'h3C5A);
      wait_frame_done(0);
      check("f1.dac_word",  cap[0],   16'hA5C3);
      check("f1.rises",     rises[0], 16);
      check("f1.cs_len",    len[0],   132);
      check("f1.adc_out",   adc_a[0], 16'h3C5A);
      check("f1.valid_cs",  vrise[0], 1'b1);
      v0 = valid_cnt[0];
      repeat (3) @(negedge clk);
      check("f1.valid_width", valid_cnt[0] - v0, 0);
      check("f1.valid_low",   valid_a[0], 1'b0);

      // dac_in changes mid-frame: transmitted word unaffected.
      start_frame(0, 16'hA5C3, 16'h1234);
      repeat (10) @(negedge clk);
      dac_in[0] = 16'hFFFF;
      wait_frame_done(0);
      check("f2.dac_word", cap[0],   16'hA5C3);
      check("f2.adc_out",  adc_a[0], 16'h1234);

      // Second adc_clock edge 50 cycles in: overrun, same frame length, no restart.
      start_frame(0, 16'h0F0F, 16'h8001);
      f0 = frames[0];
      repeat (44) @(negedge clk);
      adc_clock[0] = 1'b0;
      repeat (5) @(negedge clk);
      adc_clock[0] = 1'b1;
      wait_frame_done(0);
      check("ovr.cs_len",  len[0],   132);
      check("ovr.flag",    ovr_a[0], 1'b1);
      check("ovr.adc_out", adc_a[0], 16'h8001);
      repeat (10) @(negedge clk);
      check("ovr.no_restart", frames[0], f0);
      check("ovr.idle",       busy_a[0], 1'b0);
      clr[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      check("ovr.cleared", ovr_a[0], 1'b0);

      // Clear coincident with a new overrun edge: set wins.
      start_frame(0, 16'h5555, 16'hAAAA);
      repeat (20) @(negedge clk);
      adc_clock[0] = 1'b0;
      repeat (5) @(negedge clk);
      adc_clock[0] = 1'b1;
      clr[0]       = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      check("ovr.set_wins", ovr_a[0], 1'b1);
      wait_frame_done(0);
      clr[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      check("ovr.cleared2", ovr_a[0], 1'b0);

      // Reset 40 cycles into a frame: abort, no valid, adc_out cleared.
      start_frame(0, 16'h1357, 16'h2468);
      repeat (39) @(negedge clk);
      v0    = valid_cnt[0];
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst.cs",      cs_a[0],   1'b1);
      check("mrst.sclk",    sclk_a[0], 1'b0);
      check("mrst.adc_out", adc_a[0],  16'h0000);
      repeat (5) @(negedge clk);
      check("mrst.no_valid", valid_cnt[0] - v0, 0);
      start_frame(0, 16'hC001, 16'h7E81);
      wait_frame_done(0);
      check("mrst.next_len",  len[0],   132);
      check("mrst.next_adc",  adc_a[0], 16'h7E81);
      check("mrst.next_word", cap[0],   16'hC001);

      // Minimum timing instance.
      start_frame(1, 16'hFFFF, 16'h0000);
      wait_frame_done(1);
      check("min1.cs_len",  len[1],   34);
      check("min1.adc_out", adc_a[1], 16'h0000);
      check("min1.mosi",    cap[1],   16'hFFFF);
      check("min1.rises",   rises[1], 16);
      start_frame(1, 16'h0000, 16'hFFFF);
      wait_frame_done(1);
      check("min2.cs_len",  len[1],   34);
      check("min2.adc_out", adc_a[1], 16'hFFFF);
      check("min2.mosi",    cap[1],   16'h0000);

      // Edge on the HOLD-exit cycle counts as busy: overrun, no restart.
      start_frame(1, 16'h00FF, 16'hF00F);
      f0 = frames[1];
      adc_clock[1] = 1'b0;
      repeat (33) @(negedge clk);
      adc_clock[1] = 1'b1;
      repeat (10) @(negedge clk);
      check("hx.overrun",    ovr_a[1],  1'b1);
      check("hx.no_restart", frames[1], f0);
      check("hx.adc_out",    adc_a[1],  16'hF00F);
      clr[1] = 1'b1;
      @(negedge clk);
      clr[1] = 1'b0;

      // Edge on the cycle after returning to IDLE is accepted.
      start_frame(1, 16'h6C6C, 16'h9393);
      f0 = frames[1];
      adc_clock[1] = 1'b0;
      repeat (34) @(negedge clk);
      dac_in[1]    = 16'h3535;
      miso_word[1] = 16'h4242;
      adc_clock[1] = 1'b1;
      @(negedge clk);
      check("b2b.cs",      cs_a[1],   1'b0);
      check("b2b.frames",  frames[1], f0 + 1);
      check("b2b.overrun", ovr_a[1],  1'b0);
      check("b2b.adc_out", adc_a[1],  16'h9393);
      wait_frame_done(1);
      check("b2b.word",    cap[1],    16'h3535);
      check("b2b.adc2",    adc_a[1],  16'h4242);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_sample_xfer.md
Name: spi_sample_xfer

Overview:
Per-sample SPI frame engine between the pedal's external ADC/DAC pins and the on-chip datapath. Each rising edge of adc_clock starts one full-duplex SPI frame. The frame shifts the current processed sample (dac_in) out on MOSI and captures the next raw ADC sample from MISO. The captured word is presented to the compression/adder path as adc_out with a one-cycle adc_valid strobe.

Parameters:
DATA_W, 16, sample width in bits, transmitted MSB first.
CLK_DIV, 4, clk cycles per sclk half-period; must be ≥1.
CS_SETUP, 2, clk cycles from cs falling to the first sclk rising-half; must be ≥1.
CS_HOLD, 2, clk cycles from the last sclk falling edge to cs rising; must be ≥1.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  synchronous reset, active-low.
adc_clock  in  1  sample-rate clock, synchronous to clk; a rising edge requests a frame.
dac_in  in  DATA_W  output sample to transmit; latched at frame start.
miso  in  1  serial data from the ADC.
overrun_clr  in  1  clears the sticky overrun flag.
mosi  out  1  serial data to the DAC.
sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
cs  out  1  chip select, active-low.
adc_out  out  DATA_W  last captured ADC sample; holds between frames.
adc_valid  out  1  one-cycle pulse when adc_out updates.
busy  out  1  high whenever state is not IDLE.
overrun  out  1  sticky flag: an adc_clock edge arrived while busy.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state=IDLE; cs=1, sclk=0, mosi=0, adc_out=0, adc_valid=0, busy=0, overrun=0.
  - adc_clock history register=1, so no frame starts until adc_clock is seen low and then high.
- Edge detect: start = adc_clock & ~adc_clock_q. adc_clock_q is a plain register, with no synchroniser.
- States and transitions:
  - IDLE: on start, latch tx_sr<=dac_in, cs<=0, mosi<=dac_in[DATA_W-1], and go to SETUP.
  - SETUP: count CS_SETUP cycles with sclk=0, then go to SHIFT with bit_cnt=0.
  - SHIFT: each bit lasts 2*CLK_DIV cycles, sclk low for CLK_DIV then high for CLK_DIV.
    - On the cycle sclk goes 0→1, shift miso into rx_sr LSB.
    - On the cycle sclk goes 1→0, shift tx_sr left and mosi<=next bit.
    - After bit DATA_W-1's falling edge, go to HOLD; mosi is don't-care in HOLD (drive 0).
  - HOLD: count CS_HOLD cycles, then assert in the same cycle cs<=1, adc_out<=rx_sr, adc_valid<=1, and go to IDLE.
- Frame length is CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD clk cycles of cs low; defaults give 132.
- adc_valid rises on the cycle cs returns high. Exactly DATA_W sclk rising edges occur per frame.
- Minimum back-to-back spacing: a start seen on the cycle after returning to IDLE is accepted.
- dac_in changes after frame start have no effect on the current frame.
- start while not IDLE:
  - The edge is ignored (no queuing) and overrun<=1.
  - If set and overrun_clr occur in the same cycle, set wins.
  - overrun_clr in IDLE with no pending edge gives overrun<=0.
- start in the same cycle as the return to IDLE (HOLD exit) counts as busy → overrun; the frame is not restarted.
- Reset mid-frame: outputs take reset values on the next edge. No adc_valid is produced and the partial rx data is discarded.
- Arithmetic: counters are unsigned and sized $clog2 of their maximum + 1. No wrap-around is reachable inside a frame.

Decomposition:
- pedal_pkg:
  - SAMPLE_W=16.
  - Enum state_t {IDLE, SETUP, SHIFT, HOLD}.
  - Shared by the spi, compression and adder stages.
- One sub-module, spi_clk_div:
  - Free-running half-period counter, enabled only in SHIFT.
  - Outputs sclk plus one-cycle rise_stb/fall_stb.
  - Parameterised by CLK_DIV.
  - Cleared whenever the enable is low.

Test Plan:
1. Reset: hold rst_n=0 with adc_clock=1 → cs=1, sclk=0, mosi=0, adc_out=0, busy=0, overrun=0. Releasing with adc_clock still high starts no frame.
2. Single frame (defaults): dac_in=16'hA5C3, MISO model returns 16'h3C5A.
   - DAC model captures 16'hA5C3 and adc_out=16'h3C5A.
   - Exactly 16 sclk rises; cs low for 132 cycles.
   - adc_valid high for exactly 1 cycle, on the cycle cs rises.
3. dac_in changes to 16'hFFFF 10 cycles after cs falls → transmitted word is still 16'hA5C3.
4. Second adc_clock rising edge 50 cycles into a frame → overrun=1, frame length unchanged, no second frame.
   - overrun_clr pulse afterwards → overrun=0.
   - overrun_clr coincident with a new overrun edge → overrun stays 1.
5. rst_n=0 for 1 cycle at cycle 40 of a frame → cs=1 and sclk=0 next cycle, no adc_valid, adc_out=0. The next adc_clock edge gives a clean full frame.
6. CLK_DIV=1, CS_SETUP=1, CS_HOLD=1:
   - dac_in=16'hFFFF, miso=0 → cs low 34 cycles, adc_out=16'h0000, mosi high for all 16 bits.
   - Repeat with dac_in=16'h0000, miso=1 → adc_out=16'hFFFF.
